// File: rtl/rf_write_arbiter_if.sv
// Writeback request / register-file write / hazard-lookup bundle for rf_write_arbiter.
// The arbiter sits on the slave modport; requesters, the register file and decode sit on master.
interface rf_write_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              req0_valid;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_reg;
   logic [DATA_W-1:0] req0_data;
   logic              req1_valid;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_reg;
   logic [DATA_W-1:0] req1_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_reg;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] chk_reg1;
   logic [ADDR_W-1:0] chk_reg2;
   logic              chk_pend1;
   logic              chk_pend2;
   logic              busy;

   modport slave (
      input  req0_valid, req0_reg, req0_data,
      input  req1_valid, req1_reg, req1_data,
      input  chk_reg1, chk_reg2,
      output req0_ready, req1_ready,
      output wr_en, wr_reg, wr_data,
      output chk_pend1, chk_pend2, busy
   );

   modport master (
      output req0_valid, req0_reg, req0_data,
      output req1_valid, req1_reg, req1_data,
      output chk_reg1, chk_reg2,
      input  req0_ready, req1_ready,
      input  wr_en, wr_reg, wr_data,
      input  chk_pend1, chk_pend2, busy
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between two FIFO-buffered writeback sources
// with round-robin arbitration and RAW lookup over every write not yet committed.
module rf_write_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 2
) (
   input logic              clk,
   input logic              rst,
   rf_write_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} srcT;

   logic [ADDR_W-1:0] fifoReg  [2][DEPTH];
   logic [DATA_W-1:0] fifoData [2][DEPTH];
   logic [PTR_W-1:0]  rdPtr    [2];
   logic [PTR_W-1:0]  wrPtr    [2];
   logic [CNT_W-1:0]  count    [2];

   logic [1:0]        inValid, inReady, push, pop, nonEmpty;
   logic [ADDR_W-1:0] inReg  [2];
   logic [DATA_W-1:0] inData [2];

   srcT               lastGrant, grantSrc;
   logic              grantValid;
   logic [ADDR_W-1:0] headReg;
   logic [DATA_W-1:0] headData;

   logic              wrEn;
   logic [ADDR_W-1:0] wrReg;
   logic [DATA_W-1:0] wrData;
   logic              pend1, pend2;
   logic [PTR_W-1:0]  slotIdx;

   assign inValid   = {bus.req1_valid, bus.req0_valid};
   assign inReg[0]  = bus.req0_reg;
   assign inReg[1]  = bus.req1_reg;
   assign inData[0] = bus.req0_data;
   assign inData[1] = bus.req1_data;

   // Ready looks only at the registered count, so a full FIFO never passes through.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         nonEmpty[i] = (count[i] != '0);
         inReady[i]  = !rst && (count[i] < CNT_W'(DEPTH));
         push[i]     = inValid[i] && inReady[i];
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      grantValid = nonEmpty[0] || nonEmpty[1];
      grantSrc   = SRC0;
      if (nonEmpty[0] && nonEmpty[1])
         grantSrc = (lastGrant == SRC0) ? SRC1 : SRC0;
      else if (nonEmpty[1])
         grantSrc = SRC1;
      pop[0]   = grantValid && (grantSrc == SRC0);
      pop[1]   = grantValid && (grantSrc == SRC1);
      headReg  = (grantSrc == SRC1) ? fifoReg[1][rdPtr[1]]  : fifoReg[0][rdPtr[0]];
      headData = (grantSrc == SRC1) ? fifoData[1][rdPtr[1]] : fifoData[0][rdPtr[0]];
   end

   // NOTE: state is updated with <= so every flop samples pre-edge values regardless of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            rdPtr[i] <= '0;
            wrPtr[i] <= '0;
            count[i] <= '0;
         end
         lastGrant <= SRC1;
         wrEn      <= 1'b0;
         wrReg     <= '0;
         wrData    <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wrPtr[i] <= wrPtr[i] + PTR_W'(1);
            if (pop[i])  rdPtr[i] <= rdPtr[i] + PTR_W'(1);
            count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         end
         if (nonEmpty[0] && nonEmpty[1]) lastGrant <= grantSrc;
         wrEn <= grantValid;
         if (grantValid) begin
            wrReg  <= headReg;
            wrData <= headData;
         end
      end
   end

   // NOTE: FIFO storage has no reset; the counts alone decide which slots are live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            fifoReg[i][wrPtr[i]]  <= inReg[i];
            fifoData[i][wrPtr[i]] <= inData[i];
         end
      end
   end

   // A register is pending while it sits in a live FIFO slot or in the output stage.
   always_comb begin
      pend1   = wrEn && (wrReg == bus.chk_reg1);
      pend2   = wrEn && (wrReg == bus.chk_reg2);
      slotIdx = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            slotIdx = rdPtr[i] + PTR_W'(j);
            if (CNT_W'(j) < count[i]) begin
               if (fifoReg[i][slotIdx] == bus.chk_reg1) pend1 = 1'b1;
               if (fifoReg[i][slotIdx] == bus.chk_reg2) pend2 = 1'b1;
            end
         end
      end
   end

   assign bus.req0_ready = inReady[0];
   assign bus.req1_ready = inReady[1];
   assign bus.wr_en      = wrEn;
   assign bus.wr_reg     = wrReg;
   assign bus.wr_data    = wrData;
   assign bus.chk_pend1  = pend1;
   assign bus.chk_pend2  = pend2;
   assign bus.busy       = nonEmpty[0] || nonEmpty[1] || wrEn;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single write, round-robin contention,
// backpressure, same-edge push/pop and mid-operation reset, all with hand-computed values.
module tb_rf_write_arbiter;
   logic clk;
   logic rst;
   int   assertCount;
   int   failCount;

   rf_write_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   rf_write_arbiter #(.DATA_W(16), .ADDR_W(4), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backpressure table: one row per cycle, inputs driven before the edge, outputs checked then.
   int v0T   [9] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
   int r0T   [9] = '{4, 5, 0, 0, 0, 0, 0, 0, 0};
   int v1T   [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
   int r1T   [9] = '{10, 11, 12, 12, 13, 13, 0, 0, 0};
   int rdyT  [9] = '{1, 1, 0, 1, 0, 1, 1, 1, 1};
   int enT   [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
   int regT  [9] = '{0, 0, 4, 10, 5, 11, 12, 13, 13};
   int dataT [9] = '{0, 0, 'hA004, 'hB00A, 'hA005, 'hB00B, 'hB00C, 'hB00D, 'hB00D};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [3:0] r, input logic [15:0] d);
      bus.req0_valid = v;
      bus.req0_reg   = r;
      bus.req0_data  = d;
   endtask

   task automatic drive1(input logic v, input logic [3:0] r, input logic [15:0] d);
      bus.req1_valid = v;
      bus.req1_reg   = r;
      bus.req1_data  = d;
   endtask

   task automatic doReset();
      rst = 1'b1;
      drive0(1'b0, 4'd0, 16'd0);
      drive1(1'b0, 4'd0, 16'd0);
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst = 1'b1;
      drive0(1'b0, 4'd0, 16'd0);
      drive1(1'b0, 4'd0, 16'd0);
      bus.chk_reg1 = 4'd0;
      bus.chk_reg2 = 4'd0;

      // Reset then idle
      step();
      check("rst_wr_en",   bus.wr_en, 0);
      check("rst_wr_reg",  bus.wr_reg, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_busy",    bus.busy, 0);
      check("rst_ready0",  bus.req0_ready, 0);
      check("rst_ready1",  bus.req1_ready, 0);
      step();
      check("rst2_ready0", bus.req0_ready, 0);
      rst = 1'b0;
      #1;
      check("idle_ready0", bus.req0_ready, 1);
      check("idle_ready1", bus.req1_ready, 1);
      check("idle_busy",   bus.busy, 0);
      check("idle_wr_en",  bus.wr_en, 0);

      // Single write: push at edge k, output loaded at k+1, dropped at k+2
      drive0(1'b1, 4'd3, 16'hBEEF);
      bus.chk_reg1 = 4'd3;
      #1;
      check("single_pend_before", bus.chk_pend1, 0);
      step();
      drive0(1'b0, 4'd0, 16'd0);
      #1;
      check("single_pend_queued", bus.chk_pend1, 1);
      check("single_wr_en_k",     bus.wr_en, 0);
      check("single_busy_k",      bus.busy, 1);
      step();
      check("single_wr_en",   bus.wr_en, 1);
      check("single_wr_reg",  bus.wr_reg, 3);
      check("single_wr_data", bus.wr_data, 16'hBEEF);
      check("single_pend_out", bus.chk_pend1, 1);
      step();
      check("single_wr_en_off", bus.wr_en, 0);
      check("single_pend_off",  bus.chk_pend1, 0);
      check("single_busy_off",  bus.busy, 0);
      check("single_reg_hold",  bus.wr_reg, 3);

      // Contention round-robin: expect 1,8,2,9
      doReset();
      drive0(1'b1, 4'd1, 16'h0001);
      drive1(1'b1, 4'd8, 16'h0008);
      step();
      drive0(1'b1, 4'd2, 16'h0002);
      drive1(1'b1, 4'd9, 16'h0009);
      #1;
      check("rr_ready0", bus.req0_ready, 1);
      check("rr_ready1", bus.req1_ready, 1);
      step();
      drive0(1'b0, 4'd0, 16'd0);
      drive1(1'b0, 4'd0, 16'd0);
      bus.chk_reg1 = 4'd9;
      bus.chk_reg2 = 4'd5;
      #1;
      check("rr_wr_reg0",  bus.wr_reg, 1);
      check("rr_wr_data0", bus.wr_data, 1);
      check("rr_pend_deep", bus.chk_pend1, 1);
      check("rr_pend_none", bus.chk_pend2, 0);
      begin
         logic [3:0] rrExp [3];
         rrExp[0] = 4'd8;
         rrExp[1] = 4'd2;
         rrExp[2] = 4'd9;
         for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rr_wr_en%0d", i + 1),   bus.wr_en, 1);
            check($sformatf("rr_wr_reg%0d", i + 1),  bus.wr_reg, rrExp[i]);
            check($sformatf("rr_wr_data%0d", i + 1), bus.wr_data, {12'd0, rrExp[i]});
         end
      end
      step();
      check("rr_wr_en_off", bus.wr_en, 0);
      check("rr_busy_off",  bus.busy, 0);

      // Full backpressure on req1 while req0 competes
      doReset();
      for (int c = 0; c < 9; c++) begin
         drive0(v0T[c][0], 4'(r0T[c]), 16'hA000 | 16'(r0T[c]));
         drive1(v1T[c][0], 4'(r1T[c]), 16'hB000 | 16'(r1T[c]));
         #1;
         check($sformatf("bp_ready1_c%0d", c),  bus.req1_ready, 32'(rdyT[c]));
         check($sformatf("bp_wr_en_c%0d", c),   bus.wr_en, 32'(enT[c]));
         check($sformatf("bp_wr_reg_c%0d", c),  bus.wr_reg, 32'(regT[c]));
         check($sformatf("bp_wr_data_c%0d", c), bus.wr_data, 32'(dataT[c]));
         step();
      end
      check("bp_busy_end", bus.busy, 0);

      // Simultaneous push/pop on FIFO0: writes 6,7,14 in order, ready never drops
      drive0(1'b1, 4'd6, 16'h0606);
      #1;
      check("pp_ready_e1", bus.req0_ready, 1);
      step();
      drive0(1'b1, 4'd7, 16'h0707);
      #1;
      check("pp_ready_e2", bus.req0_ready, 1);
      check("pp_wr_en_e2", bus.wr_en, 0);
      step();
      drive0(1'b1, 4'd14, 16'h0E0E);
      bus.chk_reg1 = 4'd6;
      bus.chk_reg2 = 4'd7;
      #1;
      check("pp_ready_e3",  bus.req0_ready, 1);
      check("pp_wr_reg_e3", bus.wr_reg, 6);
      check("pp_wr_data_e3", bus.wr_data, 16'h0606);
      check("pp_pend_out",  bus.chk_pend1, 1);
      check("pp_pend_fifo", bus.chk_pend2, 1);
      step();
      drive0(1'b0, 4'd0, 16'd0);
      #1;
      check("pp_wr_reg_e4",  bus.wr_reg, 7);
      check("pp_wr_data_e4", bus.wr_data, 16'h0707);
      check("pp_pend_gone",  bus.chk_pend1, 0);
      step();
      check("pp_wr_reg_e5",  bus.wr_reg, 14);
      check("pp_wr_data_e5", bus.wr_data, 16'h0E0E);
      step();
      check("pp_wr_en_off", bus.wr_en, 0);

      // Reset mid-operation discards everything queued
      drive0(1'b1, 4'd1, 16'h1111);
      drive1(1'b1, 4'd2, 16'h2222);
      step();
      drive0(1'b1, 4'd3, 16'h3333);
      drive1(1'b1, 4'd4, 16'h4444);
      step();
      drive0(1'b0, 4'd0, 16'd0);
      drive1(1'b0, 4'd0, 16'd0);
      bus.chk_reg1 = 4'd1;
      bus.chk_reg2 = 4'd4;
      #1;
      check("mid_pend1_before", bus.chk_pend1, 1);
      check("mid_pend2_before", bus.chk_pend2, 1);
      check("mid_wr_en_before", bus.wr_en, 1);
      rst = 1'b1;
      #1;
      check("mid_ready0_rst", bus.req0_ready, 0);
      check("mid_ready1_rst", bus.req1_ready, 0);
      step();
      rst = 1'b0;
      #1;
      check("mid_wr_en",   bus.wr_en, 0);
      check("mid_wr_reg",  bus.wr_reg, 0);
      check("mid_wr_data", bus.wr_data, 0);
      check("mid_busy",    bus.busy, 0);
      for (int r = 0; r < 16; r++) begin
         bus.chk_reg1 = 4'(r);
         bus.chk_reg2 = 4'(15 - r);
         #1;
         check($sformatf("mid_pend1_r%0d", r), bus.chk_pend1, 0);
         check($sformatf("mid_pend2_r%0d", r), bus.chk_pend2, 0);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("mid_quiet_wr_en%0d", c), bus.wr_en, 0);
         check($sformatf("mid_quiet_busy%0d", c),  bus.busy, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
